// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared writeback definitions: grant source encoding and the hard-wired zero register.
package regfile_wb_arbiter_pkg;

    typedef enum logic {
        WB_SRC_A = 1'b0,
        WB_SRC_B = 1'b1
    } wb_src_e;

    localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/regfile_wb_arbiter_fifo.sv
// wb_fifo: DEPTH-entry queue of {index, data} results awaiting the register-file write port.
// Exposes per-entry valid/index so the top can compare decode sources against queued writes.
module wb_fifo #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic [ADDR_W-1:0]              push_reg,
    input  logic [DATA_W-1:0]              push_data,
    input  logic                           pop,
    output logic [ADDR_W-1:0]              head_reg,
    output logic [DATA_W-1:0]              head_data,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH):0]         count,
    output logic [DEPTH-1:0]               ent_valid,
    output logic [DEPTH-1:0][ADDR_W-1:0]   ent_reg
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [DEPTH-1:0][ADDR_W-1:0] reg_q;
    logic [DEPTH-1:0][DATA_W-1:0] data_q;
    logic [DEPTH-1:0]             vld_q;
    logic [PW-1:0]                wr_ptr;
    logic [PW-1:0]                rd_ptr;
    logic [CW-1:0]                count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_q   <= '0;
            data_q  <= '0;
            vld_q   <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            // Push never targets a full queue and pop never an empty one, so the
            // two slot indices differ whenever both fire.
            if (push) begin
                reg_q[wr_ptr]  <= push_reg;
                data_q[wr_ptr] <= push_data;
                vld_q[wr_ptr]  <= 1'b1;
                wr_ptr         <= wr_ptr + PW'(1);
            end
            if (pop) begin
                vld_q[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_reg  = reg_q[rd_ptr];
    assign head_data = data_q[rd_ptr];
    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign ent_valid = vld_q;
    assign ent_reg   = reg_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register-file write port between pipeline writeback (A) and queued
// long-latency results (B), with bounded starvation of B and decode hazard flags.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    a_valid,
    output logic                    a_ready,
    input  logic [ADDR_W-1:0]       a_reg,
    input  logic [DATA_W-1:0]       a_data,
    input  logic                    b_valid,
    output logic                    b_ready,
    input  logic [ADDR_W-1:0]       b_reg,
    input  logic [DATA_W-1:0]       b_data,
    input  logic [ADDR_W-1:0]       rd_reg1,
    input  logic [ADDR_W-1:0]       rd_reg2,
    output logic                    hazard1,
    output logic                    hazard2,
    output logic                    reg_write,
    output logic [ADDR_W-1:0]       write_reg,
    output logic [DATA_W-1:0]       write_data,
    output logic [$clog2(DEPTH):0]  b_count
);

    localparam int unsigned SW = $clog2(STARVE_MAX + 1);

    logic                         fifo_push;
    logic                         fifo_pop;
    logic                         fifo_full;
    logic                         fifo_empty;
    logic [ADDR_W-1:0]            head_reg;
    logic [DATA_W-1:0]            head_data;
    logic [DEPTH-1:0]             ent_valid;
    logic [DEPTH-1:0][ADDR_W-1:0] ent_reg;

    logic [SW-1:0]                starve_q;
    logic                         force_b;
    logic                         grant_any;
    wb_src_e                      grant;
    logic [ADDR_W-1:0]            sel_reg;
    logic [DATA_W-1:0]            sel_data;
    logic                         sel_writes;

    wb_fifo #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_reg  (b_reg),
        .push_data (b_data),
        .pop       (fifo_pop),
        .head_reg  (head_reg),
        .head_data (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (b_count),
        .ent_valid (ent_valid),
        .ent_reg   (ent_reg)
    );

    assign b_ready   = !fifo_full;
    assign fifo_push = b_valid && b_ready;

    // B is only ever taken from the queue head, so a result pushed this cycle
    // waits at least one cycle. a_ready is high only when A is valid and wins.
    always_comb begin
        force_b    = !fifo_empty && (!a_valid || (starve_q == SW'(STARVE_MAX)));
        grant      = force_b ? WB_SRC_B : WB_SRC_A;
        grant_any  = force_b || a_valid;
        fifo_pop   = force_b;
        a_ready    = a_valid && !force_b;
        sel_reg    = (grant == WB_SRC_B) ? head_reg  : a_reg;
        sel_data   = (grant == WB_SRC_B) ? head_data : a_data;
        sel_writes = grant_any && (sel_reg != ADDR_W'(REG_ZERO));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q <= '0;
        end else if (fifo_empty || force_b) begin
            starve_q <= '0;
        end else if (a_valid) begin
            starve_q <= starve_q + SW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_write  <= 1'b0;
            write_reg  <= '0;
            write_data <= '0;
        end else begin
            reg_write <= sel_writes;
            if (sel_writes) begin
                write_reg  <= sel_reg;
                write_data <= sel_data;
            end
        end
    end

    // The output stage counts as pending: the register file reads on the low phase.
    always_comb begin
        hazard1 = 1'b0;
        hazard2 = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (ent_valid[i] && (ent_reg[i] == rd_reg1)) hazard1 = 1'b1;
            if (ent_valid[i] && (ent_reg[i] == rd_reg2)) hazard2 = 1'b1;
        end
        if (b_valid && (b_reg == rd_reg1)) hazard1 = 1'b1;
        if (b_valid && (b_reg == rd_reg2)) hazard2 = 1'b1;
        if (reg_write && (write_reg == rd_reg1)) hazard1 = 1'b1;
        if (reg_write && (write_reg == rd_reg2)) hazard2 = 1'b1;
        if (rd_reg1 == ADDR_W'(REG_ZERO)) hazard1 = 1'b0;
        if (rd_reg2 == ADDR_W'(REG_ZERO)) hazard2 = 1'b0;
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus random traffic, all checked
// against a queue-based reference model of the write-port arbitration rules.
module tb_regfile_wb_arbiter;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned ADDR_W     = 5;
    localparam int unsigned DEPTH      = 2;
    localparam int unsigned STARVE_MAX = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              a_valid, a_ready, b_valid, b_ready;
    logic [ADDR_W-1:0] a_reg, b_reg, rd_reg1, rd_reg2, write_reg;
    logic [DATA_W-1:0] a_data, b_data, write_data;
    logic              hazard1, hazard2, reg_write;
    logic [$clog2(DEPTH):0] b_count;

    regfile_wb_arbiter #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .DEPTH      (DEPTH),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .a_valid    (a_valid),
        .a_ready    (a_ready),
        .a_reg      (a_reg),
        .a_data     (a_data),
        .b_valid    (b_valid),
        .b_ready    (b_ready),
        .b_reg      (b_reg),
        .b_data     (b_data),
        .rd_reg1    (rd_reg1),
        .rd_reg2    (rd_reg2),
        .hazard1    (hazard1),
        .hazard2    (hazard2),
        .reg_write  (reg_write),
        .write_reg  (write_reg),
        .write_data (write_data),
        .b_count    (b_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: pending B results as a plain queue, plus starvation tally and output stage.
    logic [ADDR_W+DATA_W-1:0] m_q[$];
    int                       m_starve;
    logic                     m_rw;
    logic [ADDR_W-1:0]        m_wr;
    logic [DATA_W-1:0]        m_wd;

    logic s_a_ready, s_b_ready, s_h1, s_h2;
    int   s_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_haz(input logic [ADDR_W-1:0] rd, input logic vb, input logic [ADDR_W-1:0] br);
        if (rd == 0) return 1'b0;
        foreach (m_q[i]) if (m_q[i][ADDR_W+DATA_W-1:DATA_W] == rd) return 1'b1;
        if (vb && br == rd) return 1'b1;
        if (m_rw && m_wr == rd) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_starve = 0;
        m_rw     = 1'b0;
        m_wr     = '0;
        m_wd     = '0;
    endtask

    task automatic cycle(input logic va, input logic [ADDR_W-1:0] ar, input logic [DATA_W-1:0] ad,
                         input logic vb, input logic [ADDR_W-1:0] br, input logic [DATA_W-1:0] bd,
                         input logic [ADDR_W-1:0] r1, input logic [ADDR_W-1:0] r2);
        bit                       take_b, e_ar, e_br, was_empty, win;
        logic [ADDR_W+DATA_W-1:0] head;
        logic [ADDR_W-1:0]        wr;
        logic [DATA_W-1:0]        wd;
        @(negedge clk);
        a_valid = va; a_reg = ar; a_data = ad;
        b_valid = vb; b_reg = br; b_data = bd;
        rd_reg1 = r1; rd_reg2 = r2;
        #1;
        was_empty = (m_q.size() == 0);
        e_br      = (m_q.size() < DEPTH);
        take_b    = !was_empty && (!va || m_starve == STARVE_MAX);
        e_ar      = va && !take_b;
        chk("a_ready", a_ready, e_ar);
        chk("b_ready", b_ready, e_br);
        chk("b_count", b_count, m_q.size());
        chk("hazard1", hazard1, m_haz(r1, vb, br));
        chk("hazard2", hazard2, m_haz(r2, vb, br));
        s_a_ready = a_ready; s_b_ready = b_ready; s_h1 = hazard1; s_h2 = hazard2;
        s_cnt     = int'(b_count);

        win = 1'b0; wr = '0; wd = '0;
        if (take_b) begin
            head = m_q.pop_front();
            win  = 1'b1;
            wr   = head[ADDR_W+DATA_W-1:DATA_W];
            wd   = head[DATA_W-1:0];
        end else if (va) begin
            win = 1'b1; wr = ar; wd = ad;
        end
        if (was_empty || take_b) m_starve = 0;
        else if (va)             m_starve++;
        if (vb && e_br) m_q.push_back({br, bd});
        m_rw = win && (wr != 0);
        if (m_rw) begin
            m_wr = wr;
            m_wd = wd;
        end

        @(posedge clk);
        #1;
        chk("reg_write",  reg_write,  m_rw);
        chk("write_reg",  write_reg,  m_wr);
        chk("write_data", write_data, m_wd);
    endtask

    task automatic idle(input logic [ADDR_W-1:0] r1);
        cycle(1'b0, '0, '0, 1'b0, '0, '0, r1, '0);
    endtask

    initial begin
        rst = 1'b1;
        a_valid = 1'b0; a_reg = '0; a_data = '0;
        b_valid = 1'b0; b_reg = '0; b_data = '0;
        rd_reg1 = '0; rd_reg2 = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_reg_write",  reg_write,  1'b0);
        chk("rst_write_reg",  write_reg,  '0);
        chk("rst_write_data", write_data, '0);
        chk("rst_b_count",    b_count,    '0);
        chk("rst_b_ready",    b_ready,    1'b1);
        chk("rst_a_ready",    a_ready,    1'b0);

        // Single A write lands one cycle later, then holds with reg_write low.
        cycle(1'b1, 5'd8, 32'd5, 1'b0, '0, '0, '0, '0);
        chk("a8_reg_write", reg_write, 1'b1);
        chk("a8_write_reg", write_reg, 5'd8);
        chk("a8_write_data", write_data, 32'd5);
        idle('0);
        chk("a8_idle_rw", reg_write, 1'b0);
        chk("a8_idle_hold", write_reg, 5'd8);

        // Two B results queued behind A, then drained in order.
        cycle(1'b1, 5'd9, 32'h99, 1'b1, 5'd2, 32'h22, 5'd2, 5'd3);
        chk("b2_hazard1", s_h1, 1'b1);
        chk("b2_count", b_count, 1);
        cycle(1'b1, 5'd9, 32'h99, 1'b1, 5'd3, 32'h33, 5'd2, 5'd3);
        chk("b3_count", b_count, 2);
        idle(5'd2);
        chk("b2_hazard_q", s_h1, 1'b1);
        chk("b2_written", write_reg, 5'd2);
        chk("b2_data", write_data, 32'h22);
        idle(5'd2);
        chk("b2_hazard_out", s_h1, 1'b1);
        chk("b3_written", write_reg, 5'd3);
        idle(5'd2);
        chk("b2_hazard_clear", s_h1, 1'b0);

        // Starvation bound: A wins STARVE_MAX cycles with B pending, then B is forced.
        cycle(1'b1, 5'd10, 32'hA0, 1'b1, 5'd4, 32'h44, '0, '0);
        for (int i = 0; i < STARVE_MAX; i++) begin
            cycle(1'b1, 5'd10, 32'hA1 + i, 1'b0, '0, '0, 5'd4, '0);
            chk("starve_a_ready", s_a_ready, 1'b1);
            chk("starve_a_write", write_reg, 5'd10);
        end
        cycle(1'b1, 5'd10, 32'hAF, 1'b0, '0, '0, '0, '0);
        chk("forced_a_ready", s_a_ready, 1'b0);
        chk("forced_b_write", write_reg, 5'd4);
        cycle(1'b1, 5'd10, 32'hB0, 1'b0, '0, '0, '0, '0);
        chk("resume_a_ready", s_a_ready, 1'b1);
        chk("resume_a_write", write_reg, 5'd10);

        // Full queue: b_ready low, reopens one cycle after the pop.
        cycle(1'b1, 5'd11, 32'h11, 1'b1, 5'd5, 32'h55, '0, '0);
        cycle(1'b1, 5'd11, 32'h12, 1'b1, 5'd6, 32'h66, '0, '0);
        cycle(1'b1, 5'd11, 32'h13, 1'b1, 5'd7, 32'h77, '0, '0);
        chk("full_b_ready", s_b_ready, 1'b0);
        chk("full_count", s_cnt, 2);
        cycle(1'b0, '0, '0, 1'b1, 5'd7, 32'h77, '0, '0);
        chk("pop_full_b_ready", s_b_ready, 1'b0);
        chk("pop_full_write", write_reg, 5'd5);
        cycle(1'b0, '0, '0, 1'b1, 5'd7, 32'h77, '0, '0);
        chk("reopen_b_ready", s_b_ready, 1'b1);
        chk("reopen_write", write_reg, 5'd6);
        idle('0);
        chk("pushpop_count", s_cnt, 1);
        chk("last_write", write_reg, 5'd7);

        // Register 0 is consumed without a write and never flags a hazard.
        cycle(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF, 5'd0, 5'd0);
        chk("r0_a_ready", s_a_ready, 1'b1);
        chk("r0_hazard1", s_h1, 1'b0);
        chk("r0_reg_write", reg_write, 1'b0);
        idle('0);
        chk("r0_b_reg_write", reg_write, 1'b0);

        // Asynchronous reset with two entries queued.
        cycle(1'b1, 5'd12, 32'hC0, 1'b1, 5'd13, 32'hD0, '0, '0);
        cycle(1'b1, 5'd12, 32'hC1, 1'b1, 5'd14, 32'hD1, '0, '0);
        @(negedge clk);
        a_valid = 1'b0; b_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_reg_write",  reg_write,  1'b0);
        chk("arst_write_reg",  write_reg,  '0);
        chk("arst_write_data", write_data, '0);
        chk("arst_b_count",    b_count,    '0);
        chk("arst_b_ready",    b_ready,    1'b1);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        idle(5'd13);
        chk("arst_no_stale", reg_write, 1'b0);
        chk("arst_no_hazard", s_h1, 1'b0);

        // Random traffic over a small index range so hazards and zero writes occur often.
        for (int n = 0; n < 3000; n++) begin
            cycle($urandom_range(0, 99) < 65, 5'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 99) < 40, 5'($urandom_range(0, 7)), $urandom,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
